// File: rtl/seq_gen_if.sv
// Word stream handshake between the sequence generator and its consumer.
interface seq_gen_if #(
  parameter int DW = 64
);
  logic          data_en;
  logic [DW-1:0] data_value;
  logic          data_ready;

  modport master (output data_en, output data_value, input data_ready);
  modport slave  (input data_en, input data_value, output data_ready);
endinterface

// File: rtl/seq_gen.sv
// Incrementing/decrementing word stream generator with burst/gap shaping,
// run length limit, graceful stop and single-word bit-0 error injection.
//   state   | meaning
//   S_IDLE  | no run active, waiting for start
//   S_BURST | presenting words, holding each until accepted
//   S_GAP   | idle cycles between bursts
module seq_gen #(
  parameter string TYPE = "INC",
  parameter int    DW   = 64,
  parameter int    CNTW = 32,
  parameter int    SUMW = 48
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            start,
  input  logic            stop,
  input  logic [DW-1:0]   seed,
  input  logic [CNTW-1:0] burst_len,
  input  logic [CNTW-1:0] gap_len,
  input  logic [SUMW-1:0] total_len,
  input  logic            inj_err,
  seq_gen_if.master       dout,
  output logic            busy,
  output logic            done,
  output logic [SUMW-1:0] sent_cnt
);

  localparam bit INC = (TYPE == "INC");

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   exp_q, exp_d;
  logic [DW-1:0]   word_q, word_d;
  logic [CNTW-1:0] burst_len_q, burst_len_d;
  logic [CNTW-1:0] gap_len_q, gap_len_d;
  logic [SUMW-1:0] total_q, total_d;
  logic [CNTW-1:0] burst_left_q, burst_left_d;
  logic [CNTW-1:0] gap_left_q, gap_left_d;
  logic [SUMW-1:0] sent_q, sent_d;
  logic            inj_q, inj_d;
  logic            stop_q, stop_d;
  logic            done_q, done_d;

  logic            accept;
  logic [DW-1:0]   exp_step;
  logic [DW-1:0]   inj_mask;
  logic [SUMW-1:0] sent_inc;

  assign accept   = (state_q == S_BURST) && dout.data_ready;
  assign exp_step = INC ? exp_q + DW'(1) : exp_q - DW'(1);
  // a word presented on this edge absorbs a pending or same-cycle injection
  assign inj_mask = {{(DW-1){1'b0}}, inj_q | inj_err};
  assign sent_inc = sent_q + SUMW'(1);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      exp_q        <= '0;
      word_q       <= '0;
      burst_len_q  <= '0;
      gap_len_q    <= '0;
      total_q      <= '0;
      burst_left_q <= '0;
      gap_left_q   <= '0;
      sent_q       <= '0;
      inj_q        <= 1'b0;
      stop_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      word_q       <= word_d;
      burst_len_q  <= burst_len_d;
      gap_len_q    <= gap_len_d;
      total_q      <= total_d;
      burst_left_q <= burst_left_d;
      gap_left_q   <= gap_left_d;
      sent_q       <= sent_d;
      inj_q        <= inj_d;
      stop_q       <= stop_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    word_d       = word_q;
    burst_len_d  = burst_len_q;
    gap_len_d    = gap_len_q;
    total_d      = total_q;
    burst_left_d = burst_left_q;
    gap_left_d   = gap_left_q;
    sent_d       = sent_q;
    inj_d        = inj_q;
    stop_d       = stop_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_BURST;
          burst_len_d  = (burst_len == '0) ? CNTW'(1) : burst_len;
          burst_left_d = (burst_len == '0) ? CNTW'(1) : burst_len;
          gap_len_d    = gap_len;
          total_d      = total_len;
          sent_d       = '0;
          inj_d        = 1'b0;
          stop_d       = 1'b0;
          exp_d        = seed;
          word_d       = seed;
        end
      end

      S_BURST: begin
        if (inj_err) inj_d = 1'b1;
        if (accept) begin
          sent_d = sent_inc;
          exp_d  = exp_step;
          if (stop || stop_q || (total_q != '0 && sent_inc == total_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            inj_d   = 1'b0;
            stop_d  = 1'b0;
          end else if (burst_left_q == CNTW'(1)) begin
            burst_left_d = burst_len_q;
            if (gap_len_q != '0) begin
              state_d    = S_GAP;
              gap_left_d = gap_len_q;
            end else begin
              word_d = exp_step ^ inj_mask;
              inj_d  = 1'b0;
            end
          end else begin
            burst_left_d = burst_left_q - CNTW'(1);
            word_d       = exp_step ^ inj_mask;
            inj_d        = 1'b0;
          end
        end else if (stop) begin
          stop_d = 1'b1;
        end
      end

      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          inj_d   = 1'b0;
        end else begin
          if (inj_err) inj_d = 1'b1;
          if (gap_left_q == CNTW'(1)) begin
            state_d = S_BURST;
            word_d  = exp_q ^ inj_mask;
            inj_d   = 1'b0;
          end else begin
            gap_left_d = gap_left_q - CNTW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign dout.data_en    = (state_q == S_BURST);
  assign dout.data_value = word_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign sent_cnt        = sent_q;

endmodule

// File: tb/tb_seq_gen.sv
// Drives an INC and a DEC generator from the same stimulus and checks both
// against a count-based model of the word stream, plus directed literal cases.
module tb_seq_gen;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, inj_err = 1'b0, rdy = 1'b0;
  logic [63:0] seed = '0;
  logic [31:0] burst_len = '0, gap_len = '0;
  logic [47:0] total_len = '0;
  logic        busy_inc, done_inc, busy_dec, done_dec;
  logic [47:0] sent_inc, sent_dec;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  seq_gen_if #(.DW(64)) if_inc ();
  seq_gen_if #(.DW(64)) if_dec ();
  assign if_inc.data_ready = rdy;
  assign if_dec.data_ready = rdy;

  seq_gen #(.TYPE("INC"), .DW(64), .CNTW(32), .SUMW(48)) dut_inc (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop), .seed(seed),
    .burst_len(burst_len), .gap_len(gap_len), .total_len(total_len), .inj_err(inj_err),
    .dout(if_inc.master), .busy(busy_inc), .done(done_inc), .sent_cnt(sent_inc));

  seq_gen #(.TYPE("DEC"), .DW(64), .CNTW(32), .SUMW(48)) dut_dec (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop), .seed(seed),
    .burst_len(burst_len), .gap_len(gap_len), .total_len(total_len), .inj_err(inj_err),
    .dout(if_dec.master), .busy(busy_dec), .done(done_dec), .sent_cnt(sent_dec));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: word n of a run is seed +/- n; timing tracked as counts of words and gap cycles.
  logic        m_run = 0, m_pend = 0, m_stopp = 0, m_cor = 0, m_done = 0;
  logic [63:0] m_seed = '0;
  logic [47:0] m_tl = '0, m_n = '0;
  int unsigned m_bl = 1, m_gl = 0, m_gap = 0, m_inb = 0;

  initial forever begin
    @(posedge sys_clk or posedge sys_rst);
    if (sys_rst) begin
      m_run = 0; m_pend = 0; m_stopp = 0; m_cor = 0; m_done = 0;
      m_n = '0; m_gap = 0; m_inb = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_seed = seed; m_bl = (burst_len == 0) ? 1 : burst_len;
          m_gl = gap_len; m_tl = total_len; m_n = '0; m_inb = 0; m_gap = 0;
          m_pend = 0; m_stopp = 0; m_cor = 0;
        end
      end else if (m_gap != 0) begin
        if (stop) begin
          m_run = 0; m_done = 1;
        end else begin
          if (inj_err) m_pend = 1;
          m_gap--;
          if (m_gap == 0) begin m_cor = m_pend; m_pend = 0; end
        end
      end else begin
        if (inj_err) m_pend = 1;
        if (rdy) begin
          m_n++; m_inb++;
          if (stop || m_stopp || (m_tl != 0 && m_n == m_tl)) begin
            m_run = 0; m_done = 1;
          end else if (m_inb == m_bl) begin
            m_inb = 0;
            if (m_gl != 0) m_gap = m_gl;
            else begin m_cor = m_pend; m_pend = 0; end
          end else begin
            m_cor = m_pend; m_pend = 0;
          end
        end else if (stop) begin
          m_stopp = 1;
        end
      end
    end
  end

  initial forever begin
    logic m_en;
    @(negedge sys_clk);
    m_en = m_run && (m_gap == 0);
    chk("en_inc", 64'(if_inc.data_en), 64'(m_en));
    chk("en_dec", 64'(if_dec.data_en), 64'(m_en));
    if (m_en) begin
      chk("val_inc", if_inc.data_value, (m_seed + 64'(m_n)) ^ 64'(m_cor));
      chk("val_dec", if_dec.data_value, (m_seed - 64'(m_n)) ^ 64'(m_cor));
    end
    chk("busy_inc", 64'(busy_inc), 64'(m_run));
    chk("busy_dec", 64'(busy_dec), 64'(m_run));
    chk("done_inc", 64'(done_inc), 64'(m_done));
    chk("done_dec", 64'(done_dec), 64'(m_done));
    chk("sent_inc", 64'(sent_inc), 64'(m_n));
    chk("sent_dec", 64'(sent_dec), 64'(m_n));
  end

  // Capture results of one directed run; start must be high during cycle 0.
  logic [63:0] q_inc[$], q_dec[$];
  logic [31:0] en_bits;
  int done_cyc, done_hits, last_acc, err_i, err_d, recv_i;

  function automatic logic ready_for(input int mode, input int i);
    case (mode)
      0:       return ((i - 1) % 4 == 0) || ((i - 1) % 4 == 3);
      2:       return !(i >= 3 && i <= 5);
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_cap(input int ncyc, input int rmode, input int inj_at, input int stop_at);
    logic [63:0] xi, xd;
    q_inc.delete(); q_dec.delete();
    en_bits = '0; done_cyc = -1; done_hits = 0; last_acc = -1;
    err_i = 0; err_d = 0; recv_i = 0; xi = '0; xd = '0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge sys_clk);
      start   = 1'b0;
      rdy     = ready_for(rmode, i);
      inj_err = (i == inj_at);
      stop    = (i == stop_at);
      if (i < 32) en_bits[i] = if_inc.data_en;
      if (if_inc.data_en && rdy) begin
        if (q_inc.size() != 0 && if_inc.data_value != xi) err_i++;
        xi = if_inc.data_value + 64'd1;
        q_inc.push_back(if_inc.data_value);
        recv_i++; last_acc = i;
      end
      if (if_dec.data_en && rdy) begin
        if (q_dec.size() != 0 && if_dec.data_value != xd) err_d++;
        xd = if_dec.data_value - 64'd1;
        q_dec.push_back(if_dec.data_value);
      end
      if (done_inc) begin done_hits++; done_cyc = i; end
    end
    inj_err = 1'b0; stop = 1'b0;
  endtask

  task automatic begin_run(input logic [63:0] s, input int bl, input int gl, input int tl);
    @(negedge sys_clk);
    seed = s; burst_len = bl; gap_len = gl; total_len = tl; start = 1'b1; rdy = 1'b1;
  endtask

  logic [63:0] inj_exp [6];

  initial begin
    inj_exp[0] = 64'd0; inj_exp[1] = 64'd1; inj_exp[2] = 64'd2;
    inj_exp[3] = 64'd2; inj_exp[4] = 64'd4; inj_exp[5] = 64'd5;

    repeat (2) @(negedge sys_clk);
    chk("rst_en", 64'(if_inc.data_en), 64'd0);
    chk("rst_val", if_inc.data_value, 64'd0);
    chk("rst_busy", 64'(busy_inc), 64'd0);
    chk("rst_done", 64'(done_inc), 64'd0);
    chk("rst_sent", 64'(sent_inc), 64'd0);
    sys_rst = 1'b0;

    // basic INC run with a gap
    begin_run(64'h10, 4, 2, 8);
    run_cap(13, 1, 0, 0);
    chk("basic_en_pattern", 64'(en_bits[11:1]), 64'b01111001111);
    chk("basic_words", q_inc.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < q_inc.size()) chk("basic_val", q_inc[i], 64'h10 + 64'(i));
    chk("basic_done_cyc", done_cyc, 11);
    chk("basic_done_hits", done_hits, 1);
    chk("basic_sent", 64'(sent_inc), 64'd8);
    chk("basic_err_cnt", err_i, 0);
    chk("basic_recv_cnt", recv_i, 8);

    // DEC wrap through zero
    begin_run(64'd1, 1, 0, 3);
    run_cap(6, 1, 0, 0);
    chk("dec_words", q_dec.size(), 3);
    if (q_dec.size() == 3) begin
      chk("dec_w0", q_dec[0], 64'd1);
      chk("dec_w1", q_dec[1], 64'd0);
      chk("dec_w2", q_dec[2], 64'hFFFF_FFFF_FFFF_FFFF);
    end
    chk("dec_err_cnt", err_d, 0);
    chk("dec_done_cyc", done_cyc, 4);

    // backpressure 1,0,0,1 with short bursts and gaps
    begin_run(64'h40, 2, 1, 5);
    run_cap(16, 0, 0, 0);
    chk("bp_words", q_inc.size(), 5);
    if (q_inc.size() == 5) chk("bp_last", q_inc[4], 64'h44);
    chk("bp_last_acc", last_acc, 12);
    chk("bp_done_cyc", done_cyc, 13);
    chk("bp_done_hits", done_hits, 1);

    // injection while word 2 is presented
    begin_run(64'd0, 6, 0, 6);
    run_cap(9, 1, 3, 0);
    chk("inj_words", q_inc.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < q_inc.size()) chk("inj_val", q_inc[i], inj_exp[i]);
    chk("inj_err_cnt", err_i, 2);

    // stop while a word is stalled, then restart
    begin_run(64'h200, 4, 0, 0);
    run_cap(10, 2, 0, 4);
    chk("stop_words", q_inc.size(), 3);
    if (q_inc.size() == 3) chk("stop_last", q_inc[2], 64'h202);
    chk("stop_done_cyc", done_cyc, 7);
    chk("stop_done_hits", done_hits, 1);
    begin_run(64'h100, 4, 0, 2);
    run_cap(5, 1, 0, 0);
    chk("restart_words", q_inc.size(), 2);
    if (q_inc.size() == 2) begin
      chk("restart_w0", q_inc[0], 64'h100);
      chk("restart_w1", q_inc[1], 64'h101);
    end
    chk("restart_sent", 64'(sent_inc), 64'd2);

    // asynchronous reset mid-burst
    begin_run(64'h7, 8, 0, 0);
    repeat (3) @(negedge sys_clk);
    start = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_en", 64'(if_inc.data_en), 64'd0);
    chk("arst_busy", 64'(busy_inc), 64'd0);
    done_hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (i == 1) sys_rst = 1'b0;
      if (done_inc) done_hits++;
    end
    chk("arst_no_done", done_hits, 0);
    chk("arst_sent", 64'(sent_inc), 64'd0);

    // randomized runs checked by the model
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 30; c++) begin
        @(negedge sys_clk);
        if (c == 0) begin
          seed = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom(), $urandom()};
          burst_len = $urandom_range(0, 4);
          gap_len   = $urandom_range(0, 3);
          total_len = ($urandom_range(0, 3) == 0) ? 48'd0 : 48'($urandom_range(1, 12));
        end
        start   = (c == 0) || ($urandom_range(0, 19) == 0);
        stop    = ($urandom_range(0, 29) == 0);
        inj_err = ($urandom_range(0, 9) == 0);
        rdy     = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 149) == 0) begin
          #2 sys_rst = 1'b1;
          @(negedge sys_clk);
          sys_rst = 1'b0;
        end
      end
      @(negedge sys_clk);
      start = 1'b0; inj_err = 1'b0; stop = 1'b1; rdy = 1'b1;
      @(negedge sys_clk);
      stop = 1'b0;
      for (int k = 0; k < 20 && busy_inc; k++) @(negedge sys_clk);
      chk("drain_idle", 64'(busy_inc), 64'd0);
    end

    @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
